// File: rtl/ads8684_spi_model.sv
// Cycle-based model of the ADS8684 SPI port: oversamples csn/sclk/sdi on clk, decodes
// 16-bit commands and returns the selected channel code on sdo in the next frame.
// Optional AUTO channel sequencing is enabled by defining ADS8684_AUTO_SEQ_EN.
module ads8684_spi_model #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        sclk,
  input  logic        sdi,
  input  logic [15:0] ain_0p,
  input  logic [15:0] ain_1p,
  input  logic [15:0] ain_2p,
  input  logic [15:0] ain_3p,
  output logic        sdo
);

  localparam int unsigned CMD_W = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(32);
  localparam logic [CNT_W-1:0] CMD_BITS = CNT_W'(CMD_W);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, sdi_sync_q;
  logic                   csn_prev_q, sclk_prev_q;
  logic [CMD_W-1:0]       cmd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [OUT_W-1:0]       out_q;
  logic [1:0]             chan_q, chan_d;
  mode_e                  mode_q, mode_d;

  logic             csn_s, sclk_s, sdi_s;
  logic             csn_rise, csn_fall, sclk_fall;
  logic [CMD_W-1:0] cmd_eff;
  logic [15:0]      ain_sel;

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign sdo       = out_q[OUT_W-1];

  // Command decode at frame end; frames shorter than 16 bits behave as NO_OP.
  always_comb begin
    mode_d  = mode_q;
    chan_d  = chan_q;
    cmd_eff = (cnt_q >= CMD_BITS) ? cmd_q : '0;
    case (cmd_eff)
      16'hC000, 16'hC400, 16'hC800, 16'hCC00: begin
        mode_d = MODE_MANUAL;
        chan_d = cmd_eff[11:10];
      end
      16'h8500: begin
        mode_d = MODE_MANUAL;
        chan_d = 2'd0;
      end
`ifdef ADS8684_AUTO_SEQ_EN
      16'hA000: begin
        mode_d = MODE_AUTO;
        chan_d = 2'd0;
      end
`endif
      default: begin
        if (mode_q == MODE_AUTO) chan_d = chan_q + 2'd1;
      end
    endcase
    case (chan_d)
      2'd0:    ain_sel = ain_0p;
      2'd1:    ain_sel = ain_1p;
      2'd2:    ain_sel = ain_2p;
      default: ain_sel = ain_3p;
    endcase
  end

  // Idle levels (csn high, sclk low) preload the synchronisers so reset release makes no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      chan_q      <= 2'd0;
      mode_q      <= MODE_MANUAL;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      csn_prev_q  <= csn_s;
      sclk_prev_q <= sclk_s;

      // A frame-end load takes priority over a coincident output shift.
      if (csn_rise) begin
        mode_q <= mode_d;
        chan_q <= chan_d;
        out_q  <= {ain_sel, 16'h0000};
      end else if (sclk_fall) begin
        out_q <= {out_q[OUT_W-2:0], 1'b0};
      end

      // Only the first 16 captured bits form the command; the counter saturates at 32.
      if (csn_fall) begin
        cnt_q <= '0;
        cmd_q <= '0;
      end else if (!csn_s && sclk_fall) begin
        if (cnt_q < CNT_MAX)  cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q < CMD_BITS) cmd_q <= {cmd_q[CMD_W-2:0], sdi_s};
      end
    end
  end

endmodule

// File: tb/tb_ads8684_spi_model.sv
// Randomised bench for ads8684_spi_model against a command-level model of the ADC.
// Honours ADS8684_AUTO_SEQ_EN the same way the design does.
module tb_ads8684_spi_model;

  localparam int unsigned HALF = 4;

  logic        clk = 1'b0;
  logic        rst, csn, sclk, sdi;
  logic [15:0] ain [4];
  logic        sdo;

  int total = 0;
  int bad   = 0;

  int          m_chan;
  bit          m_auto;
  logic [31:0] m_pending;

  always #5 clk = ~clk;

  ads8684_spi_model #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .csn    (csn),
    .sclk   (sclk),
    .sdi    (sdi),
    .ain_0p (ain[0]),
    .ain_1p (ain[1]),
    .ain_2p (ain[2]),
    .ain_3p (ain[3]),
    .sdo    (sdo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Command-level behaviour of the ADC: what a frame does to channel/mode and the next word.
  task automatic model_frame_end(input logic [15:0] cmd, input int captured);
    int c;
    c = (captured >= 16) ? int'(cmd) : 0;
    if (c == 'hC000 || c == 'hC400 || c == 'hC800 || c == 'hCC00) begin
      m_auto = 1'b0;
      m_chan = (c - 'hC000) / 'h400;
    end else if (c == 'h8500) begin
      m_auto = 1'b0;
      m_chan = 0;
`ifdef ADS8684_AUTO_SEQ_EN
    end else if (c == 'hA000) begin
      m_auto = 1'b1;
      m_chan = 0;
`endif
    end else if (m_auto) begin
      m_chan = (m_chan + 1) % 4;
    end
    m_pending = {ain[m_chan], 16'h0000};
  endtask

  // Drive nbits sclk pulses; sdo sampled before each rising edge. With tie_end the last
  // falling edge coincides with csn rising. With idle, csn stays high throughout.
  task automatic spi_frame(input logic [31:0] tx, input int nbits, input bit tie_end,
                           input bit idle, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    csn = idle;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 32) ? tx[31-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 32) rx[31-i] = sdo;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (!(tie_end && i == nbits - 1)) repeat (HALF) @(negedge clk);
    end
    csn = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [15:0] cmd, input int nbits, input bit tie_end);
    logic [31:0] rx, mask;
    int          captured;
    spi_frame({cmd, 16'h0000}, nbits, tie_end, 1'b0, rx);
    mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
    check_eq(tag, rx & mask, m_pending & mask);
    captured = tie_end ? nbits - 1 : nbits;
    model_frame_end(cmd, captured);
  endtask

  task automatic idle_read(input string tag);
    logic [31:0] rx;
    spi_frame(32'hFFFF_FFFF, 32, 1'b0, 1'b1, rx);
    check_eq(tag, rx, m_pending);
    m_pending = '0;
  endtask

  initial begin
    logic [15:0] cmds [8];
    logic [15:0] rc;
    int          nb;
    cmds = '{16'hC000, 16'hC400, 16'hC800, 16'hCC00, 16'hA000, 16'h8500, 16'h0000, 16'h1234};

    rst = 1'b1; csn = 1'b1; sclk = 1'b0; sdi = 1'b0;
    for (int k = 0; k < 4; k++) ain[k] = '0;
    m_chan = 0; m_auto = 1'b0; m_pending = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_sdo", {31'd0, sdo}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_reset_sdo", {31'd0, sdo}, 32'd0);

    ain[0] = 16'hCAFE;
    do_frame("manual_ch0_cmd", 16'hC000, 32, 1'b0);
    idle_read("manual_ch0_read");

    ain = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_frame("sel_ch1", 16'hC400, 32, 1'b0);
    do_frame("sel_ch3", 16'hCC00, 32, 1'b0);
    do_frame("sel_ch2", 16'hC800, 32, 1'b0);
    ain[2] = 16'hBEEF;
    do_frame("noop_prep", 16'hC800, 32, 1'b0);
    ain[2] = 16'h1234;
    do_frame("noop_hold", 16'h0000, 32, 1'b0);

    ain = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    do_frame("rst_cmd", 16'h8500, 32, 1'b0);
    do_frame("auto_start", 16'hA000, 32, 1'b0);
    for (int k = 0; k < 4; k++) do_frame("auto_step", 16'h0000, 32, 1'b0);

    do_frame("short_setup", 16'hC400, 32, 1'b0);
    do_frame("short_frame", 16'hCC00, 8, 1'b0);
    do_frame("short_after", 16'h0000, 32, 1'b0);
    do_frame("long_frame", 16'hC800, 40, 1'b0);
    do_frame("tie_end", 16'hCC00, 17, 1'b1);
    do_frame("tie_after", 16'h0000, 32, 1'b0);

    // Abort a 0xCC00 frame with reset after 10 bits.
    @(negedge clk);
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rc = 16'hCC00;
      sdi = rc[15-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_eq("midframe_rst_sdo", {31'd0, sdo}, 32'd0);
    csn = 1'b1; sdi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_chan = 0; m_auto = 1'b0; m_pending = '0;
    repeat (4) @(negedge clk);
    do_frame("after_rst_noop", 16'h0000, 32, 1'b0);
    idle_read("after_rst_ain0");

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) ain[k] = 16'($urandom);
      rc = cmds[$urandom_range(7)];
      if (rc == 16'h1234) rc = 16'($urandom);
      case ($urandom_range(7))
        0:       nb = $urandom_range(15, 1);
        1:       nb = $urandom_range(40, 33);
        2:       nb = $urandom_range(31, 16);
        default: nb = 32;
      endcase
      if ($urandom_range(9) == 0) idle_read("rand_idle");
      do_frame("rand_frame", rc, nb, ($urandom_range(5) == 0) && nb > 1);
    end
    idle_read("final_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    bad++;
    $display("FAIL timeout: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
